// File: rtl/int_seq6502_pkg.sv
// int_seq6502_pkg: shared kind codes, vector low bytes and a width helper
// for the 6502 interrupt/reset sequencer.
// Imported by int_seq6502 and irq_prio_enc.
package int_seq6502_pkg;

   // Interrupt kind codes as reported on int_kind
   localparam logic [1:0] INT_RESET = 2'd0;
   localparam logic [1:0] INT_NMI   = 2'd1;
   localparam logic [1:0] INT_IRQ   = 2'd2;
   localparam logic [1:0] INT_BRK   = 2'd3;

   // Vector low bytes; the high byte is always FF
   localparam logic [7:0] VEC_RESET_LO = 8'hFC;
   localparam logic [7:0] VEC_NMI_LO   = 8'hFA;
   localparam logic [7:0] VEC_IRQ_LO   = 8'hFE;

   // Channel index width; a single channel still needs one bit
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/int_seq6502_irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder over NUM_IRQ requests.
// Ports: i_req (request vector), o_any (any request), o_idx (winning index).
// Purely combinational, zero latency.
module irq_prio_enc
   import int_seq6502_pkg::*;
#(
   parameter int NUM_IRQ = 4,
   parameter int IDX_W   = idx_w(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0] i_req,
   output logic               o_any,
   output logic [IDX_W-1:0]   o_idx
);

   always_comb begin
      o_any = |i_req;
      o_idx = '0;
      // Scan downwards so the lowest set index is the last assignment
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (i_req[i]) o_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/int_seq6502.sv
// int_seq6502: interrupt/reset sequencer for the 6502 core. Merges power-on
// reset, edge NMI, BRK and NUM_IRQ masked level IRQs; at each opcode boundary
// it forces the interrupt sequence and supplies vector low byte, B flag and
// stack write-inhibit.
// Ports: clk/reset (async active-high); core status sync, brk, vec_fetch, p_i;
// requests nmi, irq, irq_mask; outputs int_take, int_kind, vector_lo, b_flag,
// write_inhibit, set_i, irq_ack.
// Optional feature macro: VECTORED_IRQ_EN (per-channel IRQ vectors).
module int_seq6502
   import int_seq6502_pkg::*;
#(
   parameter int         NUM_IRQ     = 4,
   parameter logic [7:0] IRQ_VEC_TOP = 8'hF8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sync,
   input  logic               brk,
   input  logic               vec_fetch,
   input  logic               p_i,
   input  logic               nmi,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_IRQ-1:0] irq_mask,
   output logic               int_take,
   output logic [1:0]         int_kind,
   output logic [7:0]         vector_lo,
   output logic               b_flag,
   output logic               write_inhibit,
   output logic               set_i,
   output logic [NUM_IRQ-1:0] irq_ack
);

   localparam int IDX_W = idx_w(NUM_IRQ);

   localparam logic [0:0] ST_RUN = 1'b0;
   localparam logic [0:0] ST_SEQ = 1'b1;

   logic [0:0]         r_state;
   logic [1:0]         r_kind;
   logic [7:0]         r_vec;
   logic               r_b;
   logic               r_wi;
   logic               r_set_i;
   logic [NUM_IRQ-1:0] r_irq_ack;
   logic [IDX_W-1:0]   r_chan;
   logic               r_nmi_q;
   logic               r_nmi_pend;

   logic [NUM_IRQ-1:0] w_irq_req;
   logic               w_irq_any;
   logic [IDX_W-1:0]   w_irq_idx;
   logic [7:0]         w_irq_vec;
   logic               w_in_seq;
   logic               w_take_run;
   logic               w_nmi_edge;
   logic               w_nmi_accept;
   logic               w_hijack;

   // Requests are not latched: the level must be present in the sync cycle
   assign w_irq_req = irq & irq_mask & {NUM_IRQ{~p_i}};

   irq_prio_enc #(
      .NUM_IRQ (NUM_IRQ),
      .IDX_W   (IDX_W)
   ) u_prio (
      .i_req (w_irq_req),
      .o_any (w_irq_any),
      .o_idx (w_irq_idx)
   );

`ifdef VECTORED_IRQ_EN
   logic [7:0] w_chan_off;
   assign w_chan_off = 8'(w_irq_idx) - 8'd1;
   // Channel 0 shares the BRK vector; higher channels step down by 2
   assign w_irq_vec  = (w_irq_idx == '0) ? VEC_IRQ_LO
                                         : (IRQ_VEC_TOP - (w_chan_off << 1));
`else
   logic [7:0] w_unused_vec_top;
   assign w_unused_vec_top = IRQ_VEC_TOP;
   assign w_irq_vec        = VEC_IRQ_LO;
`endif

   assign w_in_seq     = (r_state == ST_SEQ);
   assign w_take_run   = sync & (r_nmi_pend | w_irq_any);
   assign w_nmi_edge   = nmi & ~r_nmi_q;
   assign w_nmi_accept = ~w_in_seq & w_take_run & r_nmi_pend;
   // An NMI arriving during an IRQ/BRK sequence steals it, unless the
   // vector is being fetched this very cycle
   assign w_hijack     = w_in_seq & ((r_kind == INT_IRQ) | (r_kind == INT_BRK))
                         & r_nmi_pend & ~vec_fetch;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_SEQ;
         r_kind     <= INT_RESET;
         r_vec      <= VEC_RESET_LO;
         r_b        <= 1'b0;
         r_wi       <= 1'b1;
         r_set_i    <= 1'b0;
         r_irq_ack  <= '0;
         r_chan     <= '0;
         r_nmi_q    <= 1'b0;
         r_nmi_pend <= 1'b0;
      end else begin
         r_nmi_q    <= nmi;
         // A new edge wins over a same-cycle clear
         r_nmi_pend <= w_nmi_edge | (r_nmi_pend & ~(w_nmi_accept | w_hijack));
         r_set_i    <= 1'b0;
         r_irq_ack  <= '0;

         if (!w_in_seq) begin
            if (w_take_run) begin
               r_state <= ST_SEQ;
               r_b     <= 1'b0;
               if (r_nmi_pend) begin
                  r_kind <= INT_NMI;
                  r_vec  <= VEC_NMI_LO;
               end else begin
                  r_kind <= INT_IRQ;
                  r_vec  <= w_irq_vec;
                  r_chan <= w_irq_idx;
               end
            end else if (brk) begin
               r_state <= ST_SEQ;
               r_kind  <= INT_BRK;
               r_vec   <= VEC_IRQ_LO;
               r_b     <= 1'b1;
            end
         end else if (vec_fetch) begin
            r_state <= ST_RUN;
            r_set_i <= 1'b1;
            r_wi    <= 1'b0;
            if (r_kind == INT_IRQ) r_irq_ack <= NUM_IRQ'(1) << r_chan;
         end else if (w_hijack) begin
            // b_flag keeps the value latched at entry
            r_kind <= INT_NMI;
            r_vec  <= VEC_NMI_LO;
         end
      end
   end

   assign int_take      = w_in_seq | w_take_run;
   assign int_kind      = r_kind;
   assign vector_lo     = r_vec;
   assign b_flag        = r_b;
   assign write_inhibit = r_wi;
   assign set_i         = r_set_i;
   assign irq_ack       = r_irq_ack;

endmodule

// File: tb/tb_int_seq6502.sv
module tb_int_seq6502;

   localparam int NV = 36;

`ifdef VECTORED_IRQ_EN
   localparam logic [7:0] IV1 = 8'hF8;
   localparam logic [7:0] IV3 = 8'hF4;
`else
   localparam logic [7:0] IV1 = 8'hFE;
   localparam logic [7:0] IV3 = 8'hFE;
`endif

   typedef struct packed {
      logic       rst, sync, brk, vf, pi, nmi;
      logic [3:0] irq, msk;
      logic       take;
      logic [1:0] kind;
      logic [7:0] vec;
      logic       b, wi, seti;
      logic [3:0] ack;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sync = 1'b0, brk = 1'b0, vec_fetch = 1'b0, p_i = 1'b0, nmi = 1'b0;
   logic [3:0] irq = 4'h0, irq_mask = 4'h0;
   logic       int_take, b_flag, write_inhibit, set_i;
   logic [1:0] int_kind;
   logic [7:0] vector_lo;
   logic [3:0] irq_ack;

   int n_tests = 0;
   int n_fail  = 0;
   vec_t tbl [NV];

   always #5 clk = ~clk;

   int_seq6502 #(.NUM_IRQ(4), .IRQ_VEC_TOP(8'hF8)) dut (
      .clk           (clk),
      .reset         (reset),
      .sync          (sync),
      .brk           (brk),
      .vec_fetch     (vec_fetch),
      .p_i           (p_i),
      .nmi           (nmi),
      .irq           (irq),
      .irq_mask      (irq_mask),
      .int_take      (int_take),
      .int_kind      (int_kind),
      .vector_lo     (vector_lo),
      .b_flag        (b_flag),
      .write_inhibit (write_inhibit),
      .set_i         (set_i),
      .irq_ack       (irq_ack)
   );

   function automatic vec_t mk(
      input logic rst, sync_i, brk_i, vf, pi, nmi_i,
      input logic [3:0] irq_i, msk,
      input logic take, input logic [1:0] kind, input logic [7:0] vec,
      input logic b, wi, seti, input logic [3:0] ack);
      vec_t v;
      v = '{rst, sync_i, brk_i, vf, pi, nmi_i, irq_i, msk,
            take, kind, vec, b, wi, seti, ack};
      return v;
   endfunction

   initial begin
      //           rst sy bk vf pi nm irq   msk    take kd vec    b wi si ack
      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 4'h0, 4'h0,  1, 0, 8'hFC, 0, 1, 0, 4'h0);
      tbl[1]  = mk(0, 1, 0, 0, 0, 0, 4'h0, 4'h0,  1, 0, 8'hFC, 0, 1, 0, 4'h0);
      tbl[2]  = mk(0, 0, 0, 1, 0, 0, 4'h0, 4'h0,  1, 0, 8'hFC, 0, 1, 0, 4'h0);
      tbl[3]  = mk(0, 0, 0, 0, 0, 0, 4'h0, 4'h0,  0, 0, 8'hFC, 0, 0, 1, 4'h0);
      // IRQ channel 1 wins over channel 2
      tbl[4]  = mk(0, 1, 0, 0, 0, 0, 4'h6, 4'hF,  1, 0, 8'hFC, 0, 0, 0, 4'h0);
      tbl[5]  = mk(0, 0, 0, 0, 0, 0, 4'h6, 4'hF,  1, 2, IV1,   0, 0, 0, 4'h0);
      tbl[6]  = mk(0, 0, 0, 1, 0, 0, 4'h0, 4'h0,  1, 2, IV1,   0, 0, 0, 4'h0);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0, 4'h0, 4'h0,  0, 2, IV1,   0, 0, 1, 4'h2);
      // I flag set, then channels masked: no take
      tbl[8]  = mk(0, 1, 0, 0, 1, 0, 4'h6, 4'hF,  0, 2, IV1,   0, 0, 0, 4'h0);
      tbl[9]  = mk(0, 1, 0, 0, 0, 0, 4'h6, 4'h9,  0, 2, IV1,   0, 0, 0, 4'h0);
      tbl[10] = mk(0, 0, 0, 0, 0, 0, 4'h0, 4'h0,  0, 2, IV1,   0, 0, 0, 4'h0);
      // NMI edge together with IRQ: NMI serviced, no ack, no retrigger
      tbl[11] = mk(0, 0, 0, 0, 0, 1, 4'h1, 4'hF,  0, 2, IV1,   0, 0, 0, 4'h0);
      tbl[12] = mk(0, 1, 0, 0, 0, 1, 4'h1, 4'hF,  1, 2, IV1,   0, 0, 0, 4'h0);
      tbl[13] = mk(0, 0, 0, 0, 0, 1, 4'h0, 4'h0,  1, 1, 8'hFA, 0, 0, 0, 4'h0);
      tbl[14] = mk(0, 0, 0, 1, 0, 1, 4'h0, 4'h0,  1, 1, 8'hFA, 0, 0, 0, 4'h0);
      tbl[15] = mk(0, 1, 0, 0, 0, 1, 4'h0, 4'h0,  0, 1, 8'hFA, 0, 0, 1, 4'h0);
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 4'h0, 4'h0,  0, 1, 8'hFA, 0, 0, 0, 4'h0);
      // BRK hijacked by NMI; repeated brk ignored; b_flag stays 1
      tbl[17] = mk(0, 0, 1, 0, 0, 0, 4'h0, 4'h0,  0, 1, 8'hFA, 0, 0, 0, 4'h0);
      tbl[18] = mk(0, 0, 0, 0, 0, 1, 4'h0, 4'h0,  1, 3, 8'hFE, 1, 0, 0, 4'h0);
      tbl[19] = mk(0, 0, 1, 0, 0, 1, 4'h0, 4'h0,  1, 3, 8'hFE, 1, 0, 0, 4'h0);
      tbl[20] = mk(0, 0, 0, 0, 0, 1, 4'h0, 4'h0,  1, 1, 8'hFA, 1, 0, 0, 4'h0);
      tbl[21] = mk(0, 0, 0, 1, 0, 1, 4'h0, 4'h0,  1, 1, 8'hFA, 1, 0, 0, 4'h0);
      tbl[22] = mk(0, 1, 0, 0, 0, 1, 4'h0, 4'h0,  0, 1, 8'hFA, 1, 0, 1, 4'h0);
      tbl[23] = mk(0, 0, 0, 0, 0, 0, 4'h0, 4'h0,  0, 1, 8'hFA, 1, 0, 0, 4'h0);
      // IRQ channel 3, NMI pending, then reset mid-sequence
      tbl[24] = mk(0, 1, 0, 0, 0, 0, 4'h8, 4'hF,  1, 1, 8'hFA, 1, 0, 0, 4'h0);
      tbl[25] = mk(0, 0, 0, 0, 0, 1, 4'h8, 4'hF,  1, 2, IV3,   0, 0, 0, 4'h0);
      tbl[26] = mk(1, 0, 0, 0, 0, 0, 4'h8, 4'hF,  1, 0, 8'hFC, 0, 1, 0, 4'h0);
      tbl[27] = mk(0, 0, 0, 1, 0, 0, 4'h0, 4'h0,  1, 0, 8'hFC, 0, 1, 0, 4'h0);
      tbl[28] = mk(0, 1, 0, 0, 0, 0, 4'h0, 4'h0,  0, 0, 8'hFC, 0, 0, 1, 4'h0);
      tbl[29] = mk(0, 0, 0, 0, 0, 0, 4'h0, 4'h0,  0, 0, 8'hFC, 0, 0, 0, 4'h0);
      // Channel 0 uses FE in both builds
      tbl[30] = mk(0, 1, 0, 0, 0, 0, 4'h1, 4'h1,  1, 0, 8'hFC, 0, 0, 0, 4'h0);
      tbl[31] = mk(0, 0, 0, 1, 0, 0, 4'h0, 4'h0,  1, 2, 8'hFE, 0, 0, 0, 4'h0);
      tbl[32] = mk(0, 0, 0, 0, 0, 0, 4'h0, 4'h0,  0, 2, 8'hFE, 0, 0, 1, 4'h1);
      // brk in the same cycle as a take: the IRQ wins, b_flag 0
      tbl[33] = mk(0, 1, 1, 0, 0, 0, 4'h1, 4'h1,  1, 2, 8'hFE, 0, 0, 0, 4'h0);
      tbl[34] = mk(0, 0, 0, 1, 0, 0, 4'h0, 4'h0,  1, 2, 8'hFE, 0, 0, 0, 4'h0);
      tbl[35] = mk(0, 0, 0, 0, 0, 0, 4'h0, 4'h0,  0, 2, 8'hFE, 0, 0, 1, 4'h1);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         reset     = tbl[i].rst;
         sync      = tbl[i].sync;
         brk       = tbl[i].brk;
         vec_fetch = tbl[i].vf;
         p_i       = tbl[i].pi;
         nmi       = tbl[i].nmi;
         irq       = tbl[i].irq;
         irq_mask  = tbl[i].msk;
         #1;
         n_tests++;
         if ({int_take, int_kind, vector_lo, b_flag, write_inhibit, set_i, irq_ack} !==
             {tbl[i].take, tbl[i].kind, tbl[i].vec, tbl[i].b, tbl[i].wi,
              tbl[i].seti, tbl[i].ack}) begin
            n_fail++;
            $display("FAIL vec%0d: got take=%b kind=%0d vec=%h b=%b wi=%b seti=%b ack=%b, want take=%b kind=%0d vec=%h b=%b wi=%b seti=%b ack=%b",
                     i, int_take, int_kind, vector_lo, b_flag, write_inhibit, set_i, irq_ack,
                     tbl[i].take, tbl[i].kind, tbl[i].vec, tbl[i].b, tbl[i].wi,
                     tbl[i].seti, tbl[i].ack);
         end
      end

      // vec_fetch held while in RUN must not pulse set_i or start a sequence
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         sync = 1'b0; brk = 1'b0; vec_fetch = 1'b1; nmi = 1'b0;
         irq = 4'h0; irq_mask = 4'h0; p_i = 1'b0;
         #1;
         n_tests++;
         if (int_take !== 1'b0 || set_i !== 1'b0 || irq_ack !== 4'h0 ||
             write_inhibit !== 1'b0) begin
            n_fail++;
            $display("FAIL run_vf%0d: got take=%b seti=%b ack=%b wi=%b, want 0 0 0000 0",
                     k, int_take, set_i, irq_ack, write_inhibit);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/int_seq6502.md
# int_seq6502

Parametrised interrupt/reset sequencer for the 6502 core. It merges power-on reset, edge-triggered NMI, software BRK and NUM_IRQ masked level IRQ channels into one request stream. At each instruction boundary it tells the core whether to force an interrupt sequence, and it supplies the vector low byte, the pushed B-flag value and the write-inhibit. This replaces the core's fixed FC/FE vector selection and gives the unused irq/nmi pins real behaviour.

## Interface
Parameters:
- NUM_IRQ, 4 — number of maskable IRQ channels, 1..8
- IRQ_VEC_TOP, 8'hF8 — vector low byte for channel 1 when vectored IRQs are compiled in (see Configuration)

Ports:
- clk  in  1  — sole clock, rising edge
- reset  in  1  — asynchronous, active-high; all state is forced while high
- sync  in  1  — core is at an opcode-fetch boundary (T0) this cycle
- brk  in  1  — core decoded BRK this cycle (T1)
- vec_fetch  in  1  — core drives the vector-low address this cycle
- p_i  in  1  — core I flag (P[2])
- nmi  in  1  — NMI request, rising-edge sensitive
- irq  in  NUM_IRQ  — level IRQ requests, active-high
- irq_mask  in  NUM_IRQ  — per-channel enable, 1 = enabled
- int_take  out  1  — force an interrupt sequence (core substitutes opcode 00)
- int_kind  out  2  — RESET=0, NMI=1, IRQ=2, BRK=3
- vector_lo  out  8  — low byte of the vector address; the high byte is always FF
- b_flag  out  1  — B bit value for the P push
- write_inhibit  out  1  — suppress stack writes (reset sequence)
- set_i  out  1  — one-cycle pulse: core sets I
- irq_ack  out  NUM_IRQ  — one-hot, one-cycle pulse naming the serviced channel

## Operation
- States: RUN and SEQ. Reset state is SEQ with kind RESET.
- NMI edge detection:
  - nmi_q registers nmi.
  - nmi_pend is set on nmi & ~nmi_q.
  - nmi_pend is cleared when an NMI is accepted or hijacks.
  - If set and clear fall on the same edge, set wins.
- IRQ request: irq_req = irq & irq_mask, qualified by ~p_i. Requests are not latched. The lowest index wins.
- int_take in RUN (Mealy, combinational): sync & (nmi_pend | |irq_req).
- int_take in SEQ: held at 1.
- RUN → SEQ on an edge where:
  - int_take=1. Kind latched as NMI if nmi_pend, else IRQ with the winning channel latched; b_flag=0.
  - or brk=1 with no take in the same cycle. Kind BRK, b_flag=1.
- NMI hijack: in SEQ with kind IRQ or BRK, nmi_pend=1 and no vec_fetch this cycle → kind becomes NMI and nmi_pend clears. b_flag keeps its latched value.
- SEQ → RUN on vec_fetch. On the same edge:
  - set_i pulses for one cycle.
  - irq_ack pulses for the latched channel, only if the final kind is IRQ.
  - write_inhibit clears.
- vector_lo by kind: RESET FC, NMI FA, BRK FE, IRQ FE (non-vectored build).
- vec_fetch while in RUN is ignored. A repeated brk while in SEQ is ignored.

## Timing
- Reset values: state SEQ, int_kind 0, vector_lo FC, int_take 1, b_flag 0, write_inhibit 1, set_i 0, irq_ack 0, nmi_pend 0, nmi_q 0.
- int_take has zero latency from sync in RUN.
- int_kind, vector_lo and b_flag are registered and valid the cycle after entry to SEQ. They stay stable until vec_fetch, except on a hijack edge.
- An NMI edge is visible as pending one cycle after nmi rises. It is serviced at the next sync.
- An IRQ must be held through the sync cycle to be taken.
- Reset asserted mid-sequence re-enters SEQ/RESET immediately and drops any pending NMI.

## Configuration
- VECTORED_IRQ_EN defined:
  - IRQ channel 0 uses FE.
  - Channel k≥1 uses IRQ_VEC_TOP − 2·(k−1).
  - BRK stays FE.
- VECTORED_IRQ_EN undefined: every IRQ channel uses FE and IRQ_VEC_TOP is unused.

## Structure
- Kind codes (INT_RESET/NMI/IRQ/BRK) and vector low constants (VEC_RESET_LO, VEC_NMI_LO, VEC_IRQ_LO) go in 6502_inc.vh beside the existing microcode defines.
- One sub-module, irq_prio_enc: a parametrised NUM_IRQ lowest-index priority encoder with outputs any and idx.

## Test plan
- Release reset, sync=1, then vec_fetch → kind 0, vector_lo FC, write_inhibit 1 until vec_fetch, then set_i pulse and write_inhibit 0.
- irq=4'b0110, irq_mask=4'b1111, p_i=0, sync → int_take=1, kind IRQ, channel 1, irq_ack=4'b0010 at vec_fetch. vector_lo is FE (plain build) or F8 (VECTORED_IRQ_EN build).
- irq active with p_i=1 or the channel masked, sync → int_take=0 and state stays RUN.
- nmi pulse and irq in the same cycle, then sync → kind NMI, vector_lo FA, no irq_ack. A second NMI edge held high produces no retrigger.
- brk, then an nmi edge before vec_fetch → kind switches to NMI, vector_lo FA, b_flag stays 1, nmi_pend cleared.
- reset pulse asserted while in SEQ/IRQ → immediately kind 0, vector_lo FC, irq_ack never pulses.
